alu_iter: RTL and testbench

- Parametrised, registered successor to the single-cycle CPU ALU.
- Generalises datapath width; adds a valid/ready issue handshake and an iterative multiply/divide unit on the previously unused op 3'b010.
- Owns the O|S|Z|C flags register.
- Sits in the pipeline execute stage; the stall logic uses in_ready to hold issue while a mul/div is in flight.

---
 rtl/alu_iter.sv | 251 +++++++++++++++++++++++++
 tb/tb_alu_iter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_iter.sv
// alu_iter: registered execute-stage ALU that owns the O|S|Z|C flags register and
// adds a one-bit-per-cycle unsigned multiply/divide unit on op 3'b010.
module alu_iter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [3:0]       alu_op,
   input  logic [WIDTH-1:0] s_1,
   input  logic [WIDTH-1:0] s_2,
   input  logic             bubble,
   output logic             out_valid,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags,
   output logic             dbg_state_o
);

   // Handshake: a slot transfers on the posedge where in_valid && in_ready. in_ready is
   // low only while ITER runs; out_valid is a one-cycle pulse with no backpressure.

   localparam int MSB = WIDTH - 1;
   localparam int CW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [2:0] OP_ALU    = 3'b000;
   localparam logic [2:0] OP_ADDI   = 3'b001;
   localparam logic [2:0] OP_MULDIV = 3'b010;
   localparam logic [2:0] OP_LUI    = 3'b011;
   localparam logic [2:0] OP_ADD4   = 3'b100;
   localparam logic [2:0] OP_ADD5   = 3'b101;
   localparam logic [2:0] OP_ZERO   = 3'b110;
   localparam logic [2:0] OP_PASS   = 3'b111;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_ITER = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [1:0]       sel_q, sel_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [3:0]       flags_q, flags_d;
   logic             out_valid_q, out_valid_d;

   logic             cin;
   logic [WIDTH:0]   add_s, addc_s, sub_s, subc_s;
   logic [WIDTH-1:0] sc_res;
   logic             sc_c, sc_o;

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_rs;
   logic             div_ge;
   logic [WIDTH-1:0] div_tr;
   logic [WIDTH-1:0] hi_step, lo_step;
   logic [WIDTH-1:0] it_res;
   logic             it_c;

   function automatic logic ovf_add(input logic a, input logic b, input logic r);
      return (a == b) && (r != a);
   endfunction

   function automatic logic ovf_sub(input logic a, input logic b, input logic r);
      return (a != b) && (r != b);
   endfunction

   assign cin    = flags_q[0];
   assign add_s  = {1'b0, s_1} + {1'b0, s_2};
   assign addc_s = add_s + {{WIDTH{1'b0}}, cin};
   assign sub_s  = {1'b0, s_2} + {1'b0, ~s_1} + {{WIDTH{1'b0}}, 1'b1};
   assign subc_s = {1'b0, s_2} + {1'b0, ~s_1} + {{WIDTH{1'b0}}, cin};

   always_comb begin : single_cycle
      sc_res = '0;
      sc_c   = 1'b0;
      sc_o   = 1'b0;
      case (op)
         OP_ALU: begin
            case (alu_op)
               4'h0: sc_res = ~(s_1 & s_2);
               4'h1: begin
                  sc_res = add_s[MSB:0];
                  sc_c   = add_s[WIDTH];
                  sc_o   = ovf_add(s_1[MSB], s_2[MSB], add_s[MSB]);
               end
               4'h2: begin
                  sc_res = addc_s[MSB:0];
                  sc_c   = addc_s[WIDTH];
                  sc_o   = ovf_add(s_1[MSB], s_2[MSB], addc_s[MSB]);
               end
               4'h3: sc_res = s_1 | s_2;
               4'h4: begin
                  sc_res = subc_s[MSB:0];
                  sc_c   = subc_s[WIDTH];
                  sc_o   = ovf_sub(s_1[MSB], s_2[MSB], subc_s[MSB]);
               end
               4'h5: sc_res = s_1 & s_2;
               4'h6: begin
                  sc_res = sub_s[MSB:0];
                  sc_c   = sub_s[WIDTH];
                  sc_o   = ovf_sub(s_1[MSB], s_2[MSB], sub_s[MSB]);
               end
               4'h7: sc_res = s_1 ^ s_2;
               4'h8: sc_res = ~s_2;
               4'h9: begin
                  sc_res = {s_2[MSB-1:0], 1'b0};
                  sc_c   = s_2[MSB];
               end
               4'hA: begin
                  sc_res = {1'b0, s_2[MSB:1]};
                  sc_c   = s_2[0];
               end
               4'hB: begin
                  sc_res = {s_2[MSB-1:0], s_2[MSB]};
                  sc_c   = s_2[MSB];
               end
               4'hC: begin
                  sc_res = {s_2[0], s_2[MSB:1]};
                  sc_c   = s_2[0];
               end
               4'hD: begin
                  sc_res = {s_2[MSB], s_2[MSB:1]};
                  sc_c   = s_2[0];
               end
               4'hE: begin
                  sc_res = {cin, s_2[MSB:1]};
                  sc_c   = s_2[0];
               end
               default: begin
                  sc_res = {s_2[MSB-1:0], cin};
                  sc_c   = s_2[MSB];
               end
            endcase
         end
         OP_ADDI: begin
            sc_res = add_s[MSB:0];
            sc_c   = add_s[WIDTH];
            sc_o   = ovf_add(s_1[MSB], s_2[MSB], add_s[MSB]);
         end
         OP_LUI, OP_PASS:  sc_res = s_1;
         OP_ADD4, OP_ADD5: sc_res = add_s[MSB:0];
         OP_ZERO:          sc_res = '0;
         default:          sc_res = '0;
      endcase
   end

   // hi/lo hold {partial product, multiplier} for mul and {remainder, dividend->quotient}
   // for div; a zero divisor naturally yields all-ones quotient and remainder s_1.
   always_comb begin : muldiv_step
      mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH + 1){1'b0}});
      div_rs  = {hi_q, lo_q[MSB]};
      div_ge  = (div_rs >= {1'b0, opnd_q});
      div_tr  = div_rs[MSB:0] - opnd_q;
      hi_step = hi_q;
      lo_step = lo_q;
      if (sel_q[1]) begin
         hi_step = div_ge ? div_tr : div_rs[MSB:0];
         lo_step = {lo_q[MSB-1:0], div_ge};
      end else begin
         hi_step = mul_sum[WIDTH:1];
         lo_step = {mul_sum[0], lo_q[MSB:1]};
      end
      it_res = lo_step;
      it_c   = 1'b0;
      case (sel_q)
         2'b00:   begin it_res = lo_step; it_c = |hi_step;  end
         2'b01:   begin it_res = hi_step; it_c = |lo_step;  end
         2'b10:   begin it_res = lo_step; it_c = ~|opnd_q;  end
         default: begin it_res = hi_step; it_c = ~|opnd_q;  end
      endcase
   end

   always_comb begin : fsm_next
      state_d     = state_q;
      cnt_d       = cnt_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      opnd_d      = opnd_q;
      sel_d       = sel_q;
      result_d    = result_q;
      flags_d     = flags_q;
      out_valid_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (in_valid && !bubble) begin
               if (op == OP_MULDIV) begin
                  state_d = S_ITER;
                  cnt_d   = '0;
                  sel_d   = alu_op[1:0];
                  hi_d    = '0;
                  lo_d    = alu_op[1] ? s_1 : s_2;
                  opnd_d  = alu_op[1] ? s_2 : s_1;
               end else begin
                  result_d    = sc_res;
                  flags_d     = {sc_o, sc_res[MSB], (sc_res == '0), sc_c};
                  out_valid_d = 1'b1;
               end
            end
         end
         S_ITER: begin
            hi_d  = hi_step;
            lo_d  = lo_step;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               state_d     = S_IDLE;
               result_d    = it_res;
               flags_d     = {1'b0, it_res[MSB], (it_res == '0), it_c};
               out_valid_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         opnd_q      <= '0;
         sel_q       <= '0;
         result_q    <= '0;
         flags_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         opnd_q      <= opnd_d;
         sel_q       <= sel_d;
         result_q    <= result_d;
         flags_q     <= flags_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready    = (state_q == S_IDLE);
   assign out_valid   = out_valid_q;
   assign result      = result_q;
   assign flags       = flags_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_iter.sv
// Bench for alu_iter: directed checks of the documented cases plus randomized
// traffic scored against an arithmetic reference model.
module tb_alu_iter;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   op = '0;
  logic [3:0]   alu_op = '0;
  logic [W-1:0] s_1 = '0;
  logic [W-1:0] s_2 = '0;
  logic         bubble = 1'b0;
  logic         out_valid;
  logic [W-1:0] result;
  logic [3:0]   flags;
  logic         dbg_state;

  alu_iter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .alu_op(alu_op), .s_1(s_1), .s_2(s_2), .bubble(bubble),
    .out_valid(out_valid), .result(result), .flags(flags),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  logic [W-1:0] exp_q[$];
  logic [3:0]   exp_flg_q[$];
  int           exp_cyc_q[$];
  logic [3:0]   mdl_flags = '0;
  logic [W-1:0] mdl_res = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // reference model: returns {O,S,Z,C, result}
  function automatic logic [W+3:0] ref_model(input logic [2:0] o, input logic [3:0] f,
                                             input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic cin);
    longint unsigned a, b, t, r, p, mask, top, ci;
    logic c, v;
    mask = (64'd1 << W) - 64'd1;
    top  = 64'd1 << (W - 1);
    a = 64'(x); b = 64'(y); ci = 64'(cin);
    p = a * b;
    c = 1'b0; v = 1'b0; r = 64'd0; t = 64'd0;
    case (o)
      3'b000: begin
        case (f)
          4'h0: r = ~(a & b) & mask;
          4'h1, 4'h2: begin
            t = a + b + ((f == 4'h2) ? ci : 64'd0);
            r = t & mask;
            c = (t > mask);
            v = ((a & top) == (b & top)) && ((r & top) != (a & top));
          end
          4'h3: r = a | b;
          4'h4: begin
            t = b + (mask - a) + ci;
            r = t & mask;
            c = (t > mask);
            v = ((a & top) != (b & top)) && ((r & top) != (b & top));
          end
          4'h5: r = a & b;
          4'h6: begin
            r = (b - a) & mask;
            c = (b >= a);
            v = ((a & top) != (b & top)) && ((r & top) != (b & top));
          end
          4'h7: r = a ^ b;
          4'h8: r = ~b & mask;
          4'h9: begin r = (b << 1) & mask; c = ((b & top) != 64'd0); end
          4'hA: begin r = b >> 1; c = ((b & 64'd1) != 64'd0); end
          4'hB: begin
            r = ((b << 1) & mask) | (((b & top) != 64'd0) ? 64'd1 : 64'd0);
            c = ((b & top) != 64'd0);
          end
          4'hC: begin
            r = (b >> 1) | (((b & 64'd1) != 64'd0) ? top : 64'd0);
            c = ((b & 64'd1) != 64'd0);
          end
          4'hD: begin r = (b >> 1) | (b & top); c = ((b & 64'd1) != 64'd0); end
          4'hE: begin r = (b >> 1) | ((ci != 64'd0) ? top : 64'd0); c = ((b & 64'd1) != 64'd0); end
          default: begin r = ((b << 1) & mask) | ci; c = ((b & top) != 64'd0); end
        endcase
      end
      3'b001: return ref_model(3'b000, 4'h1, x, y, cin);
      3'b010: begin
        case (f[1:0])
          2'b00: begin r = p & mask; c = ((p >> W) != 64'd0); end
          2'b01: begin r = p >> W; c = ((p & mask) != 64'd0); end
          2'b10: begin
            if (b == 64'd0) begin r = mask; c = 1'b1; end
            else r = a / b;
          end
          default: begin
            if (b == 64'd0) begin r = a; c = 1'b1; end
            else r = a % b;
          end
        endcase
      end
      3'b011, 3'b111: r = a;
      3'b100, 3'b101: r = (a + b) & mask;
      default: r = 64'd0;
    endcase
    return {v, ((r & top) != 64'd0), (r == 64'd0), c, r[W-1:0]};
  endfunction

  // scoreboard: every out_valid pulse must match the oldest expectation
  always @(negedge clk) begin : monitor
    logic [W-1:0] e_res;
    logic [3:0]   e_flg;
    int           e_cyc;
    if (!rst && out_valid !== 1'b0) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out_valid", out_valid, 1'b0);
      end else begin
        e_res = exp_q.pop_front();
        e_flg = exp_flg_q.pop_front();
        e_cyc = exp_cyc_q.pop_front();
        chk("sb_result", result, e_res);
        chk("sb_flags", flags, e_flg);
        chk("sb_latency", cyc, e_cyc);
      end
    end
  end

  // driver: present a slot at a negedge, hold until accepted, return at the next negedge
  task automatic issue(input logic [2:0] o, input logic [3:0] f,
                       input logic [W-1:0] a, input logic [W-1:0] b, input logic bub);
    int n;
    logic [W+3:0] m;
    in_valid = 1'b1; op = o; alu_op = f; s_1 = a; s_2 = b; bubble = bub;
    n = 0;
    while (in_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) begin
      chk("issue_timeout", in_ready, 1'b1);
    end else if (!bub) begin
      m = ref_model(o, f, a, b, mdl_flags[0]);
      exp_q.push_back(m[W-1:0]);
      exp_flg_q.push_back(m[W+3:W]);
      exp_cyc_q.push_back(cyc + 1 + ((o == 3'b010) ? W : 0));
      mdl_res   = m[W-1:0];
      mdl_flags = m[W+3:W];
    end
    @(negedge clk);
    in_valid = 1'b0;
    bubble   = 1'b0;
  endtask

  task automatic wait_ov(input string tag);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 3 * W) begin
      @(negedge clk);
      n++;
    end
    chk(tag, out_valid, 1'b1);
  endtask

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return {1'b1, {(W - 1){1'b0}}};
      3: return {1'b0, {(W - 1){1'b1}}};
      4: return W'(1);
      5: return W'($urandom_range(0, 9));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation still running at time limit, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n;
    int c0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_result", result, '0);
    chk("rst_flags", flags, 4'b0000);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_state", dbg_state, 1'b0);

    // add with carry-out to zero
    issue(3'b000, 4'h1, 16'hFFFF, 16'h0001, 1'b0);
    chk("add_ov", out_valid, 1'b1);
    chk("add_res", result, 16'h0000);
    chk("add_flags", flags, 4'b0011);

    // sub with overflow, then addc consumes C
    issue(3'b000, 4'h6, 16'h0001, 16'h8000, 1'b0);
    chk("sub_res", result, 16'h7FFF);
    chk("sub_flags", flags, 4'b1001);
    issue(3'b000, 4'h2, 16'h0000, 16'h0000, 1'b0);
    chk("addc_res", result, 16'h0001);
    chk("addc_flags", flags, 4'b0000);

    // mul low: busy for W cycles, result in cycle W+1, next op accepted there
    issue(3'b010, 4'h0, 16'h0100, 16'h0100, 1'b0);
    for (int i = 1; i <= W; i++) begin
      chk($sformatf("mul_busy_c%0d", i), in_ready, 1'b0);
      if (i < W) @(negedge clk);
    end
    @(negedge clk);
    chk("mul_done_ready", in_ready, 1'b1);
    chk("mul_done_ov", out_valid, 1'b1);
    chk("mul_res", result, 16'h0000);
    chk("mul_flags", flags, 4'b0011);
    c0 = cyc;
    issue(3'b000, 4'h1, 16'h0003, 16'h0004, 1'b0);
    chk("after_mul_accept", cyc, c0 + 1);
    chk("after_mul_res", result, 16'h0007);

    // divide, remainder, divide by zero, mul high
    issue(3'b010, 4'h2, 16'd100, 16'd7, 1'b0);
    wait_ov("div_q_done");
    chk("div_q", result, 16'd14);
    issue(3'b010, 4'h3, 16'd100, 16'd7, 1'b0);
    wait_ov("div_r_done");
    chk("div_r", result, 16'd2);
    issue(3'b010, 4'h2, 16'h1234, 16'h0000, 1'b0);
    wait_ov("div0_done");
    chk("div0_res", result, 16'hFFFF);
    chk("div0_flags", flags, 4'b0101);
    issue(3'b010, 4'h1, 16'hFFFF, 16'hFFFF, 1'b0);
    wait_ov("mulh_done");
    chk("mulh_res", result, 16'hFFFE);

    // reset mid-iteration discards the operation
    issue(3'b010, 4'h0, 16'h1234, 16'h5678, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_flags", flags, 4'b0000);
    chk("midrst_ov", out_valid, 1'b0);
    exp_q.delete(); exp_flg_q.delete(); exp_cyc_q.delete();
    mdl_flags = '0; mdl_res = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", in_ready, 1'b1);
    chk("rel_state", dbg_state, 1'b0);
    @(negedge clk);
    issue(3'b000, 4'h1, 16'h0002, 16'h0003, 1'b0);
    chk("post_rst_ov", out_valid, 1'b1);
    chk("post_rst_res", result, 16'h0005);
    repeat (20) @(negedge clk);

    // bubbles: consumed, no result, no flag update, no ITER
    issue(3'b000, 4'h1, 16'hFFFF, 16'h0001, 1'b1);
    chk("bub_ov", out_valid, 1'b0);
    chk("bub_flags", flags, mdl_flags);
    chk("bub_res", result, mdl_res);
    issue(3'b010, 4'h2, 16'd100, 16'd7, 1'b1);
    chk("bub_div_ready", in_ready, 1'b1);
    chk("bub_div_state", dbg_state, 1'b0);
    chk("bub_div_ov", out_valid, 1'b0);
    issue(3'b000, 4'h1, 16'h0001, 16'h0001, 1'b0);
    chk("after_bub_res", result, 16'h0002);

    // randomized traffic
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      issue(($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(0, 7)),
            4'($urandom_range(0, 15)), rnd_val(), rnd_val(),
            ($urandom_range(0, 7) == 0));
    end

    n = 0;
    while (exp_q.size() != 0 && n < 4 * W) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
